// File: rtl/sram_dp_clr.sv
// Simple-dual-port SRAM with byte-select writes, 1- or 2-cycle reads and a clear engine
// that zeroes the array after reset or on request.
module sram_dp_clr #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  output logic                busy_o,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W/8-1:0] wsel_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OFF_W = $clog2(SEL_W);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  typedef enum logic {StClear, StIdle} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  widx, ridx;
  logic              wr_en, rd_en, clr_wr;
  logic [DATA_W-1:0] rd_word;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;

  // Bits above the word index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr_i, raddr_i};

  assign widx   = waddr_i[OFF_W +: IDX_W];
  assign ridx   = raddr_i[OFF_W +: IDX_W];
  assign busy_o = (state_q == StClear);
  assign wr_en  = rst_n && !busy_o && we_i;
  assign rd_en  = rst_n && !busy_o && re_i;
  assign clr_wr = rst_n && busy_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (clr_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < SEL_W; k++) begin
        if (wsel_i[k]) begin
          mem_q[widx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Write-first: a same-cycle write to the read word is merged into the returned data.
  always_comb begin
    rd_word = mem_q[ridx];
    if (wr_en && (widx == ridx)) begin
      for (int k = 0; k < SEL_W; k++) begin
        if (wsel_i[k]) begin
          rd_word[8*k +: 8] = wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rdata_o  = s2_data_q;
    assign rvalid_o = s2_valid_q;
  end else begin : g_lat1
    assign rdata_o  = s1_data_q;
    assign rvalid_o = s1_valid_q;
  end

endmodule

// File: tb/tb_sram_dp_clr.sv
// Drives two configurations of sram_dp_clr with shared stimulus and compares every cycle
// against a word-array reference model, plus directed checks with fixed expected values.
module tb_sram_dp_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr_i, we_i, re_i;
  logic [31:0] waddr_i, raddr_i;
  logic [63:0] wdata_i;
  logic [7:0]  wsel_i;

  logic        busy0, rvalid0, busy1, rvalid1;
  logic [31:0] rdata0;
  logic [63:0] rdata1;

  sram_dp_clr #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .RD_LAT(1)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr_i),
    .busy_o   (busy0),
    .we_i     (we_i),
    .waddr_i  (waddr_i),
    .wsel_i   (wsel_i[3:0]),
    .wdata_i  (wdata_i[31:0]),
    .re_i     (re_i),
    .raddr_i  (raddr_i),
    .rdata_o  (rdata0),
    .rvalid_o (rvalid0)
  );

  sram_dp_clr #(.DATA_W(64), .DEPTH(512), .ADDR_W(32), .RD_LAT(2)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr_i),
    .busy_o   (busy1),
    .we_i     (we_i),
    .waddr_i  (waddr_i),
    .wsel_i   (wsel_i),
    .wdata_i  (wdata_i),
    .re_i     (re_i),
    .raddr_i  (raddr_i),
    .rdata_o  (rdata1),
    .rvalid_o (rvalid1)
  );

  int unsigned n_total, n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain word arrays, a busy-cycle countdown and a queue of due responses.
  typedef struct {
    int          dut;
    int          due;
    logic [63:0] data;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [63:0] mem_m [2][512];
  int          busy_m [2];
  logic        exp_rv [2];
  logic [63:0] exp_rd [2];
  int          cyc;

  function automatic int unsigned depth_of(input int d); return (d == 0) ? 256 : 512; endfunction
  function automatic int unsigned lat_of(input int d);   return (d == 0) ? 1 : 2;     endfunction
  function automatic int unsigned selw_of(input int d);  return (d == 0) ? 4 : 8;     endfunction
  function automatic int unsigned offw_of(input int d);  return (d == 0) ? 2 : 3;     endfunction

  task automatic zero_mem(input int d);
    for (int i = 0; i < 512; i++) mem_m[d][i] = '0;
  endtask

  task automatic model_edge();
    int unsigned widx, ridx;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        busy_m[d] = int'(depth_of(d));
        zero_mem(d);
        exp_rd[d] = '0;
      end else if (busy_m[d] > 0) begin
        busy_m[d]--;
      end else begin
        widx = (waddr_i >> offw_of(d)) % depth_of(d);
        ridx = (raddr_i >> offw_of(d)) % depth_of(d);
        if (we_i) begin
          for (int k = 0; k < int'(selw_of(d)); k++) begin
            if (wsel_i[k]) mem_m[d][widx][8*k +: 8] = wdata_i[8*k +: 8];
          end
        end
        if (re_i) rsp_q.push_back('{dut: d, due: cyc + int'(lat_of(d)) - 1, data: mem_m[d][ridx]});
        if (clr_i) begin
          busy_m[d] = int'(depth_of(d));
          zero_mem(d);
        end
      end
    end
    if (!rst_n) rsp_q.delete();
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    foreach (rsp_q[i]) begin
      if (rsp_q[i].due == cyc) begin
        exp_rv[rsp_q[i].dut] = 1'b1;
        exp_rd[rsp_q[i].dut] = rsp_q[i].data;
      end
    end
    while (rsp_q.size() > 0 && rsp_q[0].due <= cyc) void'(rsp_q.pop_front());
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("busy0",   64'(busy0),   64'(busy_m[0] > 0));
    check("busy1",   64'(busy1),   64'(busy_m[1] > 0));
    check("rvalid0", 64'(rvalid0), 64'(exp_rv[0]));
    check("rvalid1", 64'(rvalid1), 64'(exp_rv[1]));
    check("rdata0",  64'(rdata0),  exp_rd[0]);
    check("rdata1",  rdata1,       exp_rd[1]);
  endtask

  task automatic idle();
    we_i  = 1'b0;
    re_i  = 1'b0;
    clr_i = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a = (a & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
    return a;
  endfunction

  task automatic rnd_inputs();
    we_i    = 1'($urandom_range(0, 1));
    re_i    = 1'($urandom_range(0, 1));
    clr_i   = 1'b0;
    waddr_i = rnd_addr();
    raddr_i = ($urandom_range(0, 2) == 0) ? waddr_i : rnd_addr();
    wdata_i = {$urandom, $urandom};
    wsel_i  = 8'($urandom);
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] dat, input logic [7:0] sel);
    idle();
    we_i    = 1'b1;
    waddr_i = a;
    wdata_i = dat;
    wsel_i  = sel;
    tick();
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [63:0] e0,
                        input logic [63:0] e1);
    idle();
    re_i    = 1'b1;
    raddr_i = a;
    tick();
    idle();
    check({tag, "_v0"}, 64'(rvalid0), 64'd1);
    check({tag, "_d0"}, 64'(rdata0), e0);
    check({tag, "_v1_early"}, 64'(rvalid1), 64'd0);
    tick();
    check({tag, "_v1"}, 64'(rvalid1), 64'd1);
    check({tag, "_d1"}, rdata1, e1);
    check({tag, "_v0_once"}, 64'(rvalid0), 64'd0);
  endtask

  // Counts busy cycles from the current (first post-release or post-request) cycle onward.
  task automatic measure_busy(input string tag);
    int c0 = 0;
    int c1 = 0;
    int n  = 0;
    while ((busy0 || busy1) && n < 1200) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (busy0) rnd_inputs();
      else idle();
      tick();
      n++;
    end
    idle();
    check({tag, "_len0"}, 64'(c0), 64'd256);
    check({tag, "_len1"}, 64'(c1), 64'd512);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    idle();
    waddr_i = '0;
    raddr_i = '0;
    wdata_i = '0;
    wsel_i  = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    measure_busy("rst");
    rd_chk("top_zero", 32'h3FC, 64'h0, 64'h0);

    wr(32'h010, 64'hDEADBEEF, 8'h0F);
    wr(32'h010, 64'h000000AA, 8'h01);
    rd_chk("bytesel", 32'h010, 64'hDEADBEAA, 64'hDEADBEAA);
    wr(32'h010, 64'hFFFFFFFF, 8'h00);
    rd_chk("sel_zero", 32'h010, 64'hDEADBEAA, 64'hDEADBEAA);

    wr(32'h020, 64'h11223344, 8'h0F);
    we_i = 1'b1; waddr_i = 32'h020; wsel_i = 8'h0C; wdata_i = 64'hAABBCCDD;
    re_i = 1'b1; raddr_i = 32'h020;
    tick();
    idle();
    check("rw_first_d0", 64'(rdata0), 64'hAABB3344);
    tick();
    check("rw_first_d1", rdata1, 64'hAABB3344);
    rd_chk("rw_after", 32'h020, 64'hAABB3344, 64'hAABB3344);

    // A write after the read must not disturb the response already in flight.
    re_i = 1'b1; raddr_i = 32'h020;
    tick();
    idle();
    check("late_wr_d0", 64'(rdata0), 64'hAABB3344);
    we_i = 1'b1; waddr_i = 32'h020; wsel_i = 8'h03; wdata_i = 64'h5566;
    tick();
    idle();
    check("late_wr_d1", rdata1, 64'hAABB3344);
    rd_chk("late_wr_new", 32'h020, 64'hAABB5566, 64'hAABB5566);

    wr(32'h404, 64'h12345678, 8'h0F);
    rd_chk("alias_lo", 32'h004, 64'h12345678, 64'h0);
    wr(32'h1004, 64'h12345678, 8'h0F);
    rd_chk("alias_hi", 32'h004, 64'h12345678, 64'h12345678);
    wr(32'h3FC, 64'hCAFEF00D, 8'h0F);
    wr(32'h000, 64'h0BADBEEF, 8'h0F);
    rd_chk("edge_top", 32'h3FC, 64'hCAFEF00D, 64'hCAFEF00D);
    rd_chk("edge_bot", 32'h000, 64'h0BADBEEF, 64'h0BADBEEF);

    for (int i = 0; i < 4; i++) wr(32'(4 * i), 64'hA5A5_0000 + 64'(i), 8'hFF);
    clr_i = 1'b1;
    re_i  = 1'b1;
    raddr_i = 32'h000;
    tick();
    idle();
    check("clr_same_rd", 64'(rdata0), 64'hA5A5_0000);
    measure_busy("clr");
    for (int i = 0; i < 4; i++) rd_chk("cleared", 32'(4 * i), 64'h0, 64'h0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (100) begin
      rnd_inputs();
      tick();
    end
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    measure_busy("rst_mid");
    wr(32'h010, 64'hDEADBEEF, 8'h0F);
    wr(32'h010, 64'h000000AA, 8'h01);
    rd_chk("bytesel2", 32'h010, 64'hDEADBEAA, 64'hDEADBEAA);

    for (int i = 0; i < 4000; i++) begin
      rnd_inputs();
      clr_i = ($urandom_range(0, 299) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
